// File: rtl/gf_seq_pkg.sv
// Shared opcodes, FSM encoding and request legality helper for gf_op_sequencer.
package gf_seq_pkg;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_CLMUL = 2'd1;
   localparam logic [1:0] OP_GFMUL = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RED  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // A GF(2^m) multiply is only meaningful for 2 <= m <= max_gf.
   function automatic logic gf_degree_ok(input int unsigned m, input int unsigned max_gf);
      return (m >= 32'd2) && (m <= max_gf);
   endfunction

endpackage

// File: rtl/gf_op_sequencer.sv
// Sequencer driving a shared external carry-less/GF datapath for one requester.
// Optional GF_SEQ_OPCOUNT_EN adds completed-operation and error counters.
module gf_op_sequencer
   import gf_seq_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  MAX_GF     = 16,
   localparam int unsigned GW         = $clog2(DATA_WIDTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              op,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   input  logic [GW-1:0]           width,
   input  logic [DATA_WIDTH:0]     polyn_red_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] result,
   output logic                    err,
   output logic                    dp_carry_option,
   output logic                    dp_red_funct,
   output logic [DATA_WIDTH-1:0]   dp_a,
   output logic [DATA_WIDTH-1:0]   dp_b,
   output logic [GW-1:0]           dp_polyn_grade,
   output logic [DATA_WIDTH:0]     dp_polyn_red_in,
   output logic [2*DATA_WIDTH-1:0] dp_reduc_in,
   input  logic [2*DATA_WIDTH-1:0] dp_mult_out,
   input  logic [DATA_WIDTH-1:0]   dp_out_poly
`ifdef GF_SEQ_OPCOUNT_EN
   ,
   output logic [31:0]             op_count,
   output logic [15:0]             err_count
`endif
);

   state_e                  state_q;
   logic [1:0]              op_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    err_q;
   logic [2*DATA_WIDTH-1:0] result_q;
   logic                    dp_carry_q;
   logic                    dp_red_q;
   logic [DATA_WIDTH-1:0]   dp_a_q;
   logic [DATA_WIDTH-1:0]   dp_b_q;
   logic [GW-1:0]           dp_grade_q;
   logic [DATA_WIDTH:0]     dp_poly_q;
   logic [2*DATA_WIDTH-1:0] dp_reduc_q;
   logic                    req_bad_c;
   logic                    done_hs_c;

   // Illegal requests skip the datapath and complete with err.
   assign req_bad_c = (op == OP_RSVD) ||
                      ((op == OP_GFMUL) && !gf_degree_ok(32'(width), MAX_GF));
   assign done_hs_c = (state_q == S_DONE) && out_ready;

   // Operation FSM with all outputs and datapath controls registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_MULT;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         result_q    <= '0;
         dp_carry_q  <= 1'b0;
         dp_red_q    <= 1'b0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         dp_grade_q  <= '0;
         dp_poly_q   <= '0;
         dp_reduc_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_q       <= op;
                  dp_a_q     <= a;
                  dp_b_q     <= b;
                  dp_grade_q <= width;
                  dp_poly_q  <= polyn_red_in;
                  dp_carry_q <= (op == OP_MULT);
                  dp_red_q   <= 1'b0;
                  in_ready_q <= 1'b0;
                  if (req_bad_c) begin
                     err_q       <= 1'b1;
                     result_q    <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (op_q == OP_GFMUL) begin
                  dp_reduc_q <= dp_mult_out;
                  dp_red_q   <= 1'b1;
                  dp_carry_q <= 1'b0;
                  state_q    <= S_RED;
               end else begin
                  result_q    <= dp_mult_out;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_RED: begin
               result_q    <= {{DATA_WIDTH{1'b0}}, dp_out_poly};
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  dp_red_q    <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign err             = err_q;
   assign result          = result_q;
   assign dp_carry_option = dp_carry_q;
   assign dp_red_funct    = dp_red_q;
   assign dp_a            = dp_a_q;
   assign dp_b            = dp_b_q;
   assign dp_polyn_grade  = dp_grade_q;
   assign dp_polyn_red_in = dp_poly_q;
   assign dp_reduc_in     = dp_reduc_q;

`ifdef GF_SEQ_OPCOUNT_EN
   logic [31:0] op_count_q;
   logic [15:0] err_count_q;

   // Count completed result handshakes, and those that carried err.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_q  <= '0;
         err_count_q <= '0;
      end else if (done_hs_c) begin
         op_count_q <= op_count_q + 32'd1;
         if (err_q) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign op_count  = op_count_q;
   assign err_count = err_count_q;
`else
   logic unused_c;
   assign unused_c = done_hs_c;
`endif

endmodule

// File: tb/tb_gf_op_sequencer.sv
// Directed self-checking bench for gf_op_sequencer with a behavioural datapath.
module tb_gf_op_sequencer;
   import gf_seq_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned GW = $clog2(DW) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [DW-1:0]   a, b;
   logic [GW-1:0]   width;
   logic [DW:0]     polyn_red_in;
   logic            out_valid;
   logic            out_ready;
   logic [2*DW-1:0] result;
   logic            err;
   logic            dp_carry_option;
   logic            dp_red_funct;
   logic [DW-1:0]   dp_a, dp_b;
   logic [GW-1:0]   dp_polyn_grade;
   logic [DW:0]     dp_polyn_red_in;
   logic [2*DW-1:0] dp_reduc_in;
   logic [2*DW-1:0] dp_mult_out;
   logic [DW-1:0]   dp_out_poly;
`ifdef GF_SEQ_OPCOUNT_EN
   logic [31:0]     op_count;
   logic [15:0]     err_count;
   int              exp_ops = 0;
   int              exp_errs = 0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gf_op_sequencer #(.DATA_WIDTH(DW), .MAX_GF(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .width(width), .polyn_red_in(polyn_red_in),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err),
      .dp_carry_option(dp_carry_option), .dp_red_funct(dp_red_funct),
      .dp_a(dp_a), .dp_b(dp_b), .dp_polyn_grade(dp_polyn_grade),
      .dp_polyn_red_in(dp_polyn_red_in), .dp_reduc_in(dp_reduc_in),
      .dp_mult_out(dp_mult_out), .dp_out_poly(dp_out_poly)
`ifdef GF_SEQ_OPCOUNT_EN
      , .op_count(op_count), .err_count(err_count)
`endif
   );

   // Behavioural combinational datapath
   function automatic logic [2*DW-1:0] clmul(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [2*DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < int'(DW); i++)
         if (y[i]) acc ^= ({{DW{1'b0}}, x} << i);
      return acc;
   endfunction

   function automatic logic [DW-1:0] reduce(input logic [2*DW-1:0] v, input logic [DW:0] p,
                                            input logic [GW-1:0] m);
      logic [2*DW-1:0] t;
      logic [2*DW-1:0] pw;
      t  = v;
      pw = {{(DW-1){1'b0}}, p};
      for (int i = 2*int'(DW)-1; i >= 0; i--)
         if ((int'(m) <= i) && t[i]) t ^= (pw << (i - int'(m)));
      return t[DW-1:0];
   endfunction

   assign dp_mult_out = dp_carry_option ? ({{DW{1'b0}}, dp_a} * {{DW{1'b0}}, dp_b})
                                        : clmul(dp_a, dp_b);
   assign dp_out_poly = reduce(dp_reduc_in, dp_polyn_red_in, dp_polyn_grade);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, then wait (bounded) for out_valid; lat counts edges from accept.
   task automatic do_op(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [GW-1:0] m, input logic [DW:0] p, output int lat);
      op = o; a = x; b = y; width = m; polyn_red_in = p; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result(input logic exp_err);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`ifdef GF_SEQ_OPCOUNT_EN
      exp_ops++;
      if (exp_err) exp_errs++;
`else
      if (exp_err) begin end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake got in_ready=%b out_valid=%b err=%b exp 1 0 0",
                  in_ready, out_valid, err);
      end
      checks++;
      if (result !== '0 || dp_reduc_in !== '0 || dp_a !== '0 || dp_b !== '0) begin
         errors++;
         $display("FAIL reset_data got result=%0h reduc=%0h a=%0h b=%0h exp 0",
                  result, dp_reduc_in, dp_a, dp_b);
      end
      checks++;
      if (dp_carry_option !== 1'b0 || dp_red_funct !== 1'b0 || dp_polyn_grade !== '0
          || dp_polyn_red_in !== '0) begin
         errors++;
         $display("FAIL reset_dp_ctrl got carry=%b red=%b grade=%0d poly=%0h exp 0",
                  dp_carry_option, dp_red_funct, dp_polyn_grade, dp_polyn_red_in);
      end
`ifdef GF_SEQ_OPCOUNT_EN
      checks++;
      if (op_count !== 32'd0 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters got %0d %0d exp 0 0", op_count, err_count);
      end
`endif
   endtask

   task automatic test_clmul();
      int lat;
      do_op(OP_CLMUL, 32'd3, 32'd3, GW'(0), 33'd0, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL clmul_latency got %0d exp 2", lat); end
      checks++;
      if (result !== 64'd5 || err !== 1'b0) begin
         errors++; $display("FAIL clmul_result got %0h err=%b exp 5 err=0", result, err);
      end
      release_result(1'b0);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clmul_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_mult();
      op = OP_MULT; a = 32'd3; b = 32'd3; width = '0; polyn_red_in = '0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (dp_carry_option !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mult_exec got carry=%b in_ready=%b out_valid=%b exp 1 0 0",
                  dp_carry_option, in_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== 64'd9 || err !== 1'b0) begin
         errors++;
         $display("FAIL mult_result got valid=%b result=%0h err=%b exp 1 9 0",
                  out_valid, result, err);
      end
      release_result(1'b0);
   endtask

   task automatic test_gfmul();
      int lat;
      op = OP_GFMUL; a = 32'hF; b = 32'hF; width = GW'(4); polyn_red_in = 33'd19; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (dp_red_funct !== 1'b0 || dp_carry_option !== 1'b0 || dp_polyn_grade !== GW'(4)
          || dp_polyn_red_in !== 33'd19) begin
         errors++;
         $display("FAIL gf_exec got red=%b carry=%b grade=%0d poly=%0d exp 0 0 4 19",
                  dp_red_funct, dp_carry_option, dp_polyn_grade, dp_polyn_red_in);
      end
      tick();
      checks++;
      if (dp_reduc_in !== 64'h55 || dp_red_funct !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gf_red got reduc=%0h red=%b valid=%b exp 55 1 0",
                  dp_reduc_in, dp_red_funct, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== 64'hA || err !== 1'b0) begin
         errors++;
         $display("FAIL gf_result got valid=%b result=%0h err=%b exp 1 a 0", out_valid, result, err);
      end
      release_result(1'b0);
      checks++;
      if (dp_red_funct !== 1'b0) begin
         errors++; $display("FAIL gf_red_clear got %b exp 0", dp_red_funct);
      end
      do_op(OP_GFMUL, 32'd8, 32'd2, GW'(4), 33'd19, lat);
      checks++;
      if (lat !== 3 || result !== 64'd3) begin
         errors++; $display("FAIL gf_x4 got lat=%0d result=%0h exp 3 3", lat, result);
      end
      release_result(1'b0);
      do_op(OP_GFMUL, 32'h8000, 32'd2, GW'(16), 33'h1002B, lat);
      checks++;
      if (lat !== 3 || result !== 64'h2B || err !== 1'b0) begin
         errors++;
         $display("FAIL gf_deg16 got lat=%0d result=%0h err=%b exp 3 2b 0", lat, result, err);
      end
      release_result(1'b0);
   endtask

   task automatic test_errors();
      int lat;
      do_op(OP_RSVD, 32'd5, 32'd5, GW'(4), 33'd19, lat);
      checks++;
      if (lat !== 1 || err !== 1'b1 || result !== '0) begin
         errors++;
         $display("FAIL err_rsvd got lat=%0d err=%b result=%0h exp 1 1 0", lat, err, result);
      end
      release_result(1'b1);
      checks++;
      if (err !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL err_clear got err=%b in_ready=%b exp 0 1", err, in_ready);
      end
      do_op(OP_GFMUL, 32'd3, 32'd3, GW'(20), 33'd19, lat);
      checks++;
      if (lat !== 1 || err !== 1'b1 || result !== '0) begin
         errors++;
         $display("FAIL err_deg20 got lat=%0d err=%b result=%0h exp 1 1 0", lat, err, result);
      end
      release_result(1'b1);
      do_op(OP_GFMUL, 32'd3, 32'd3, GW'(1), 33'd3, lat);
      checks++;
      if (lat !== 1 || err !== 1'b1) begin
         errors++; $display("FAIL err_deg1 got lat=%0d err=%b exp 1 1", lat, err);
      end
      release_result(1'b1);
   endtask

   task automatic test_hold();
      int lat;
      do_op(OP_MULT, 32'd3, 32'd3, GW'(0), 33'd0, lat);
      for (int i = 0; i < 5; i++) begin
         op = OP_CLMUL; a = 32'd7; b = 32'd7; in_valid = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || result !== 64'd9 || in_ready !== 1'b0 || dp_a !== 32'd3) begin
            errors++;
            $display("FAIL hold_%0d got valid=%b result=%0h in_ready=%b dp_a=%0h exp 1 9 0 3",
                     i, out_valid, result, in_ready, dp_a);
         end
      end
      in_valid = 1'b0;
      release_result(1'b0);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      op = OP_CLMUL; a = 32'd3; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (out_valid) begin
            seen++;
            checks++;
            if (result !== 64'd5) begin
               errors++; $display("FAIL b2b_result got %0h exp 5", result);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (seen !== 3 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_count got %0d in_ready=%b exp 3 1", seen, in_ready);
      end
`ifdef GF_SEQ_OPCOUNT_EN
      exp_ops += 3;
`endif
   endtask

   task automatic test_reset_mid();
      op = OP_GFMUL; a = 32'hF; b = 32'hF; width = GW'(4); polyn_red_in = 33'd19; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (dp_red_funct !== 1'b1) begin
         errors++; $display("FAIL rstmid_in_red got red=%b exp 1", dp_red_funct);
      end
`ifdef GF_SEQ_OPCOUNT_EN
      checks++;
      if (op_count !== 32'(exp_ops) || err_count !== 16'(exp_errs)) begin
         errors++;
         $display("FAIL counters got %0d %0d exp %0d %0d", op_count, err_count, exp_ops, exp_errs);
      end
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || dp_red_funct !== 1'b0 || in_ready !== 1'b1
          || dp_reduc_in !== '0) begin
         errors++;
         $display("FAIL rstmid_state got valid=%b red=%b in_ready=%b reduc=%0h exp 0 0 1 0",
                  out_valid, dp_red_funct, in_ready, dp_reduc_in);
      end
`ifdef GF_SEQ_OPCOUNT_EN
      checks++;
      if (op_count !== 32'd0 || err_count !== 16'd0) begin
         errors++; $display("FAIL rstmid_counters got %0d %0d exp 0 0", op_count, err_count);
      end
`endif
      tick(); tick(); tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_no_output got valid=%b exp 0", out_valid);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      width = '0; polyn_red_in = '0;
      test_reset();
      test_clmul();
      test_mult();
      test_gfmul();
      test_errors();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf_op_sequencer.md
Name: gf_op_sequencer

Overview:
Multi-cycle controller that sequences the shared carry-less/GF datapath (integer multiply, carry-less multiply, polynomial reduction) for one requester.
- Accepts an operation over a valid/ready handshake and drives the datapath control/operand ports.
- For a GF(2^m) multiply, chains carry-less multiply then reduction.
- Returns the registered result over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand width of the datapath.
MAX_GF, 16, highest field degree accepted for GF multiply.
GW, $clog2(DATA_WIDTH)+1, width of the degree field (derived, not overridable).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  request present.
in_ready  out  1  sequencer can accept a request.
op  in  2  0=MULT (integer), 1=CLMUL, 2=GFMUL, 3=reserved.
a, b  in  DATA_WIDTH  operands.
width  in  GW  field degree m (GFMUL only).
polyn_red_in  in  DATA_WIDTH+1  irreducible polynomial (GFMUL only).
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
result  out  2*DATA_WIDTH  product; GFMUL result zero-extended.
err  out  1  qualifies out_valid; illegal op or degree.
dp_carry_option  out  1  1=integer carry, 0=carry-less.
dp_red_funct  out  1  1=reduction pass.
dp_a, dp_b  out  DATA_WIDTH  datapath operands.
dp_polyn_grade  out  GW  degree to datapath.
dp_polyn_red_in  out  DATA_WIDTH+1  polynomial to datapath.
dp_reduc_in  out  2*DATA_WIDTH  value to be reduced.
dp_mult_out  in  2*DATA_WIDTH  datapath product (combinational).
dp_out_poly  in  DATA_WIDTH  datapath reduced value (combinational).

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; err=0; result=0.
  - All dp_* outputs 0.
  - rst mid-operation aborts it: no output produced, datapath controls cleared next edge.
- FSM states: IDLE, EXEC, RED, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register op/a/b/width/polyn_red_in and drive dp_a/dp_b/dp_polyn_*.
  - dp_carry_option=(op==0), dp_red_funct=0.
  - Go to EXEC.
  - If op==3, or op==2 with width<2 or width>MAX_GF: go straight to DONE with err=1, result=0.
- EXEC:
  - Capture dp_mult_out.
  - MULT/CLMUL: result<=dp_mult_out, go to DONE.
  - GFMUL: dp_reduc_in<=dp_mult_out, dp_red_funct<=1, dp_carry_option<=0, go to RED.
- RED: result<={DATA_WIDTH'b0, dp_out_poly}, go to DONE.
- DONE:
  - out_valid=1; result/err stable while out_ready=0.
  - On out_ready: out_valid<=0, err<=0, return to IDLE, dp_red_funct<=0.
- in_ready=0 in EXEC/RED/DONE. No new request overlaps one in flight.
- Latency from the accept edge to out_valid high:
  - 2 cycles for MULT/CLMUL.
  - 3 cycles for GFMUL.
  - 1 cycle for an error.
- Throughput: one operation per latency+1 cycles when out_ready is held high.
- Operands are held on dp_* for the whole operation. The datapath is combinational and sampled only at EXEC/RED edges.

Optional Feature:
GF_SEQ_OPCOUNT_EN:
- Defined:
  - Adds outputs op_count[31:0] and err_count[15:0].
  - Each increments on every DONE->IDLE handshake; err_count only when err=1.
  - Both wrap modulo 2^n and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package gf_seq_pkg:
  - Opcode localparams OP_MULT/OP_CLMUL/OP_GFMUL/OP_RSVD.
  - FSM state encoding.
- No sub-module. The datapath stays external so it can be shared or arbitrated later.

Test Plan:
- op=1, a=3, b=3 (datapath model = carry-less multiply) -> out_valid 2 cycles after accept, result=5, err=0.
- op=0, a=3, b=3 -> result=9. dp_carry_option=1 during EXEC.
- op=2, width=4, poly=19, a=0xF, b=0xF -> dp_reduc_in=0x55 in RED; result=0xA 3 cycles after accept. Also a=8, b=2 -> result=3.
- op=3 -> err=1, result=0, 1 cycle after accept. op=2, width=20 -> err=1.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored. Release -> IDLE, in_ready=1.
- Assert rst during RED -> next cycle IDLE, out_valid=0, dp_red_funct=0. With GF_SEQ_OPCOUNT_EN, counters=0.
